shift_rows_pipe: RTL

//  Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit with a per-transfer mode bit.

---
 rtl/shift_rows_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - pipelined ShiftRows/InvShiftRows with valid/ready handshake
// Optional output beat counter enabled by SHIFT_ROWS_PIPE_CNT_EN.
module shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [32*NB-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef SHIFT_ROWS_PIPE_CNT_EN
    output logic [31:0]     beat_cnt,
`endif
    output logic [32*NB-1:0] out_state
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end

    // The 256-bit state uses a wider shift on rows 2 and 3.
    function automatic int row_off(input int r);
        if (NB == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    function automatic logic [W-1:0] permute(input logic mode, input logic [W-1:0] s);
        logic [W-1:0] o;
        int src;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (mode) src = (c - row_off(r) + NB) % NB;
                else      src = (c + row_off(r)) % NB;
                o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    logic [STAGES:1]   v;
    logic [W-1:0]      d [1:STAGES];
    logic [STAGES:1]   rdy;
    logic [STAGES-1:0] lv;
    logic [W-1:0]      ld [0:STAGES-1];

    // A stage can load if it, or any stage downstream of it, is empty, or the sink drains.
    always_comb begin
        rdy = '0;
        for (int k = 1; k <= STAGES; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j <= STAGES; j++) begin
                if (!v[j]) rdy[k] = 1'b1;
            end
        end
    end

    always_comb begin
        lv    = '0;
        lv[0] = in_valid;
        ld[0] = permute(in_mode, in_state);
        for (int k = 1; k < STAGES; k++) begin
            lv[k] = v[k];
            ld[k] = d[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 1; k <= STAGES; k++) d[k] <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= lv[k-1];
                    if (lv[k-1]) d[k] <= ld[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[1];
    assign out_valid = v[STAGES];
    assign out_state = d[STAGES];

`ifdef SHIFT_ROWS_PIPE_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      beat_cnt <= '0;
        else if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
    end
`endif

endmodule
